// File: rtl/result_ascii_tx.sv
// result_ascii_tx: converts an unsigned binary result to decimal ASCII and
// streams it, optionally followed by CR LF, over a byte valid/ready handshake.
// The conversion is double-dabble, one bit per cycle, with leading zeros suppressed.
//   clk       in  system clock, rising edge
//   n_rst     in  asynchronous active-low reset
//   calc_done in  one-cycle pulse: calc_res is valid (accepted only in IDLE)
//   calc_res  in  DATA_W-bit unsigned result
//   tx_ready  in  UART TX can take a byte this cycle
//   tx_valid  out tx_data holds a byte to send
//   tx_data   out ASCII byte (holds its last value while tx_valid=0)
//   busy      out high in every state except IDLE
//   fmt_done  out one-cycle pulse after the last byte is accepted
module result_ascii_tx #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DIGITS    = 10,
    parameter bit          SEND_CRLF = 1'b1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              calc_done,
    input  logic [DATA_W-1:0] calc_res,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              fmt_done
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_SKIP,
        S_SEND,
        S_CR,
        S_LF,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic               fmt_done_q, fmt_done_d;
    logic [BCD_W-1:0]   adj;
    logic [PTR_W-1:0]   ptr_dec;
    logic               xfer;

    // Select one BCD digit by index.
    function automatic logic [3:0] digit_sel(input logic [BCD_W-1:0] bcd,
                                             input logic [PTR_W-1:0] idx);
        digit_sel = 4'd0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx == PTR_W'(i)) digit_sel = bcd[4*i +: 4];
        end
    endfunction

    // State and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            bin_q      <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            fmt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            fmt_done_q <= fmt_done_d;
        end
    end

    // Next-state logic; outputs are computed for the next state so they leave registered.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        fmt_done_d = 1'b0;
        adj        = bcd_q;
        ptr_dec    = ptr_q - PTR_W'(1);
        xfer       = tx_valid_q & tx_ready;

        case (state_q)
            S_IDLE: begin
                if (calc_done) begin
                    bin_d   = calc_res;
                    bcd_d   = '0;
                    cnt_d   = CNT_W'(DATA_W);
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                // Add-3 correction on every digit >= 5, then shift {bcd,bin} left.
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
                end
                bcd_d = {adj[BCD_W-2:0], bin_q[DATA_W-1]};
                bin_d = {bin_q[DATA_W-2:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    ptr_d   = PTR_W'(DIGITS - 1);
                    state_d = S_SKIP;
                end
            end
            S_SKIP: begin
                // Drop leading zeros but always keep the units digit.
                if (digit_sel(bcd_q, ptr_q) == 4'd0 && ptr_q != '0) begin
                    ptr_d = ptr_dec;
                end else begin
                    state_d    = S_SEND;
                    tx_valid_d = 1'b1;
                    tx_data_d  = 8'h30 + {4'h0, digit_sel(bcd_q, ptr_q)};
                end
            end
            S_SEND: begin
                if (xfer) begin
                    if (ptr_q != '0) begin
                        ptr_d     = ptr_dec;
                        tx_data_d = 8'h30 + {4'h0, digit_sel(bcd_q, ptr_dec)};
                    end else if (SEND_CRLF) begin
                        state_d   = S_CR;
                        tx_data_d = 8'h0D;
                    end else begin
                        state_d    = S_DONE;
                        tx_valid_d = 1'b0;
                        fmt_done_d = 1'b1;
                    end
                end
            end
            S_CR: begin
                if (xfer) begin
                    state_d   = S_LF;
                    tx_data_d = 8'h0A;
                end
            end
            S_LF: begin
                if (xfer) begin
                    state_d    = S_DONE;
                    tx_valid_d = 1'b0;
                    fmt_done_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign fmt_done = fmt_done_q;

endmodule

// File: tb/tb_result_ascii_tx.sv
// tb_result_ascii_tx: directed, table-driven bench for result_ascii_tx.
module tb_result_ascii_tx;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        calc_done;
    logic [31:0] calc_res;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        busy;
    logic        fmt_done;

    int checks = 0;
    int errors = 0;

    result_ascii_tx dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .calc_done (calc_done),
        .calc_res  (calc_res),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .busy      (busy),
        .fmt_done  (fmt_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] val;
        string       exp;     // expected byte stream including CR LF
        int          lat;     // cycles from calc_done to first tx_valid
        bit          rnd;     // stall tx_ready with a fixed 1-0-0-1 style pattern
        bit          inject;  // fire extra calc_done while busy and in DONE
    } vec_t;

    vec_t vecs[7];
    bit   pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int         cyc;
        int         nb;
        bit         seen_valid;
        bit         stall;
        bit         injected;
        bit         done;
        logic [7:0] prev;
        cyc = 0; nb = 0; seen_valid = 0; stall = 0; injected = 0; done = 0; prev = 8'h00;
        @(negedge clk);
        calc_res  = v.val;
        calc_done = 1'b1;
        while (!done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            calc_done = 1'b0;
            if (stall) begin
                chk("stall_valid", 32'(tx_valid), 32'd1);
                chk("stall_data", 32'(tx_data), 32'(prev));
            end
            if (tx_valid && !seen_valid) begin
                seen_valid = 1;
                chk("latency", 32'(cyc - 1), 32'(v.lat));
            end
            chk("busy_active", 32'(busy), 32'd1);
            if (fmt_done) begin
                done = 1;
                chk("byte_count", 32'(nb), 32'(v.exp.len()));
                chk("valid_in_done", 32'(tx_valid), 32'd0);
                if (v.inject) begin
                    calc_res  = 32'd7;
                    calc_done = 1'b1;
                end
            end else begin
                tx_ready = v.rnd ? pat[cyc % 7] : 1'b1;
                if (v.inject && !injected && nb == 1) begin
                    calc_res  = 32'd7;
                    calc_done = 1'b1;
                    injected  = 1;
                end
                if (tx_valid && tx_ready) begin
                    if (nb < v.exp.len()) chk("byte", 32'(tx_data), 32'(v.exp[nb]));
                    else                  chk("extra_byte", 32'(nb), 32'(v.exp.len()));
                    nb++;
                end
                stall = tx_valid && !tx_ready;
                prev  = tx_data;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: value %0d sent %0d bytes, no fmt_done", v.val, nb);
        end
        @(negedge clk);
        calc_done = 1'b0;
        chk("fmt_done_pulse", 32'(fmt_done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("valid_idle", 32'(tx_valid), 32'd0);
        repeat (3) @(negedge clk);
        chk("stay_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int nb;
        int cyc;
        vec_t v42;

        vecs[0] = '{val: 32'd0,          exp: "0\r\n",          lat: 42, rnd: 0, inject: 0};
        vecs[1] = '{val: 32'd12345,      exp: "12345\r\n",      lat: 38, rnd: 0, inject: 0};
        vecs[2] = '{val: 32'hFFFFFFFF,   exp: "4294967295\r\n", lat: 33, rnd: 0, inject: 0};
        vecs[3] = '{val: 32'd131070,     exp: "131070\r\n",     lat: 37, rnd: 1, inject: 0};
        vecs[4] = '{val: 32'd999,        exp: "999\r\n",        lat: 40, rnd: 0, inject: 1};
        vecs[5] = '{val: 32'd7,          exp: "7\r\n",          lat: 42, rnd: 0, inject: 0};
        vecs[6] = '{val: 32'd1000000000, exp: "1000000000\r\n", lat: 33, rnd: 1, inject: 0};

        n_rst = 1'b0; calc_done = 1'b0; calc_res = '0; tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_data", 32'(tx_data), 32'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(fmt_done), 32'd0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset in the middle of sending 12345, after two bytes have been accepted.
        @(negedge clk);
        calc_res = 32'd12345; calc_done = 1'b1; tx_ready = 1'b1;
        nb = 0; cyc = 0;
        while (nb < 2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            calc_done = 1'b0;
            if (tx_valid && tx_ready) nb++;
        end
        chk("pre_reset_bytes", 32'(nb), 32'd2);
        @(posedge clk);
        #1 n_rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(tx_valid), 32'd0);
        chk("mid_rst_data", 32'(tx_data), 32'h00);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(fmt_done), 32'd0);
        @(negedge clk);
        chk("mid_rst_hold", 32'(tx_valid), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);
        v42 = '{val: 32'd42, exp: "42\r\n", lat: 41, rnd: 0, inject: 0};
        run_vec(v42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
